// File: rtl/clock_pkg.sv
// Shared encodings and defaults for the clock set sequencer.
// Holds status codes, digit masks, timing defaults and helpers.
package clock_pkg;

    typedef enum logic [2:0] {
        SHOW_TIME  = 3'd0,
        SET_HOUR   = 3'd1,
        SET_MINUTE = 3'd2,
        SET_MONTH  = 3'd3,
        SET_DAY    = 3'd4
    } status_e;

    localparam logic [3:0] MASK_ALL = 4'b1111;
    localparam logic [3:0] MASK_HI  = 4'b1100;
    localparam logic [3:0] MASK_LO  = 4'b0011;

    localparam int REPEAT_DELAY_DEF  = 50;
    localparam int REPEAT_RATE_DEF   = 10;
    localparam int TIMEOUT_TICKS_DEF = 1000;
    localparam int BLINK_HALF_DEF    = 25;

    function automatic status_e next_status(input status_e s);
        unique case (s)
            SHOW_TIME:  return SET_HOUR;
            SET_HOUR:   return SET_MINUTE;
            SET_MINUTE: return SET_MONTH;
            SET_MONTH:  return SET_DAY;
            default:    return SHOW_TIME;
        endcase
    endfunction

    function automatic logic [3:0] digit_mask(input status_e s);
        unique case (s)
            SET_HOUR,   SET_MONTH: return MASK_HI;
            SET_MINUTE, SET_DAY:   return MASK_LO;
            default:               return MASK_ALL;
        endcase
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Edge detect plus hold-to-repeat strobes for one active-low key.
// Ports: key_n/tick in, clear aborts; press, held, press_q, rep out.
module key_repeat #(
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic key_n,
    input  logic clear,
    output logic press,
    output logic held,
    output logic press_q,
    output logic rep
);

    localparam int HW = $clog2(REPEAT_DELAY + 1);
    localparam int RW = $clog2(REPEAT_RATE + 1);
    localparam logic [HW-1:0] DLY    = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] DLY_M1 = HW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_M1 = RW'(REPEAT_RATE - 1);

    logic          key_q, key_d;
    logic          prev_q, prev_d;
    logic          act_q, act_d;
    logic          press_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rate_q, rate_d;

    always_comb begin
        key_d   = key_n;
        prev_d  = key_q;
        press   = prev_q & ~key_q;
        held    = ~key_q;
        press_d = press & ~clear;
        act_d   = act_q;
        hold_d  = hold_q;
        rate_d  = rate_q;
        rep     = 1'b0;
        if (clear || !held) begin
            act_d  = 1'b0;
            hold_d = '0;
            rate_d = '0;
        end else if (press) begin
            act_d  = 1'b1;
            hold_d = '0;
            rate_d = '0;
        end else if (act_q && tick) begin
            if (hold_q != DLY) begin
                hold_d = hold_q + 1'b1;
                rep    = (hold_q == DLY_M1);
            end else if (rate_q == RATE_M1) begin
                rate_d = '0;
                rep    = 1'b1;
            end else begin
                rate_d = rate_q + 1'b1;
            end
        end
    end

    // Key flops reset to "pressed" so a key held through reset,
    // or released just after it, never looks like a fresh press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_q   <= 1'b0;
            prev_q  <= 1'b0;
            act_q   <= 1'b0;
            press_q <= 1'b0;
            hold_q  <= '0;
            rate_q  <= '0;
        end else begin
            key_q   <= key_d;
            prev_q  <= prev_d;
            act_q   <= act_d;
            press_q <= press_d;
            hold_q  <= hold_d;
            rate_q  <= rate_d;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/set sequencer: display mode FSM, increment pulses, sec gating.
// Ports: keys and tick in; status, inc_*, sec_run, show_date, digit_en out.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE   = REPEAT_RATE_DEF,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
    parameter int BLINK_HALF    = BLINK_HALF_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_10ms,
    input  logic       key_mode_n,
    input  logic       key_add_n,
    output logic [2:0] status,
    output logic       inc_minute,
    output logic       inc_hour,
    output logic       inc_day,
    output logic       inc_month,
    output logic       sec_run,
    output logic       show_date,
    output logic [3:0] digit_en
);

    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [TW-1:0] TMO   = TW'(TIMEOUT_TICKS);
    localparam logic [BW-1:0] BH_M1 = BW'(BLINK_HALF - 1);

    logic          mkey_q, mkey_d;
    logic          mprev_q, mprev_d;
    logic          mode_press;
    logic          add_press, add_held, add_first, add_rep;
    status_e       state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic [3:0]    inc_q, inc_d;
    logic          sec_run_q, sec_run_d;
    logic          show_date_q, show_date_d;
    logic [3:0]    digit_en_q, digit_en_d;
    logic          in_set, changed, fire;

    key_repeat #(
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_add (
        .clock  (clock),
        .reset  (reset),
        .tick   (tick_10ms),
        .key_n  (key_add_n),
        .clear  (mode_press),
        .press  (add_press),
        .held   (add_held),
        .press_q(add_first),
        .rep    (add_rep)
    );

    always_comb begin
        mkey_d     = key_mode_n;
        mprev_d    = mkey_q;
        mode_press = mprev_q & ~mkey_q;
        in_set     = (state_q != SHOW_TIME);

        state_d = state_q;
        if (mode_press)
            state_d = next_status(state_q);
        else if (in_set && tmo_q == TMO)
            state_d = SHOW_TIME;
        changed = (state_d != state_q);

        tmo_d = tmo_q;
        if (changed || mode_press || add_press)
            tmo_d = '0;
        else if (in_set && tick_10ms && tmo_q != TMO)
            tmo_d = tmo_q + 1'b1;

        // No increment lands in a state that is being left.
        fire  = in_set & (add_first | add_rep) & ~changed;
        inc_d = 4'b0000;
        if (fire) begin
            unique case (state_q)
                SET_MINUTE: inc_d = 4'b0001;
                SET_HOUR:   inc_d = 4'b0010;
                SET_DAY:    inc_d = 4'b0100;
                SET_MONTH:  inc_d = 4'b1000;
                default:    inc_d = 4'b0000;
            endcase
        end

        sec_run_d = sec_run_q;
        if (changed && state_d == SHOW_TIME)
            sec_run_d = 1'b1;
        else if (fire)
            sec_run_d = 1'b0;

        show_date_d = show_date_q;
        if (state_d != SHOW_TIME)
            show_date_d = 1'b0;
        else if (!in_set && add_first)
            show_date_d = ~show_date_q;

        blink_d = blink_q;
        phase_d = phase_q;
        if (changed || add_held) begin
            blink_d = '0;
            phase_d = 1'b1;
        end else if (tick_10ms) begin
            if (blink_q == BH_M1) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + 1'b1;
            end
        end

        digit_en_d = digit_mask(state_d);
        if (state_d != SHOW_TIME)
            digit_en_d = digit_en_d & {4{phase_d}};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mkey_q      <= 1'b0;
            mprev_q     <= 1'b0;
            state_q     <= SHOW_TIME;
            tmo_q       <= '0;
            blink_q     <= '0;
            phase_q     <= 1'b1;
            inc_q       <= 4'b0000;
            sec_run_q   <= 1'b1;
            show_date_q <= 1'b0;
            digit_en_q  <= MASK_ALL;
        end else begin
            mkey_q      <= mkey_d;
            mprev_q     <= mprev_d;
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            blink_q     <= blink_d;
            phase_q     <= phase_d;
            inc_q       <= inc_d;
            sec_run_q   <= sec_run_d;
            show_date_q <= show_date_d;
            digit_en_q  <= digit_en_d;
        end
    end

    assign status     = state_q;
    assign inc_minute = inc_q[0];
    assign inc_hour   = inc_q[1];
    assign inc_day    = inc_q[2];
    assign inc_month  = inc_q[3];
    assign sec_run    = sec_run_q;
    assign show_date  = show_date_q;
    assign digit_en   = digit_en_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_clock_set_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tick_10ms = 1'b0;
    logic       key_mode_n = 1'b1;
    logic       key_add_n = 1'b1;
    logic [2:0] status;
    logic       inc_minute, inc_hour, inc_day, inc_month;
    logic       sec_run, show_date;
    logic [3:0] digit_en;

    int checks = 0;
    int passes = 0;
    int n_min = 0, n_hour = 0, n_day = 0, n_month = 0, n_multi = 0;

    clock_set_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .tick_10ms (tick_10ms),
        .key_mode_n(key_mode_n),
        .key_add_n (key_add_n),
        .status    (status),
        .inc_minute(inc_minute),
        .inc_hour  (inc_hour),
        .inc_day   (inc_day),
        .inc_month (inc_month),
        .sec_run   (sec_run),
        .show_date (show_date),
        .digit_en  (digit_en)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        n_min   += int'(inc_minute);
        n_hour  += int'(inc_hour);
        n_day   += int'(inc_day);
        n_month += int'(inc_month);
        if ((int'(inc_minute) + int'(inc_hour) + int'(inc_day)
             + int'(inc_month)) > 1)
            n_multi++;
    end

    function automatic int n_all();
        return n_min + n_hour + n_day + n_month;
    endfunction

    task automatic clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        key_mode_n = 1'b1;
        key_add_n = 1'b1;
        tick_10ms = 1'b0;
        clk(3);
        reset = 1'b1;
        clk(3);
    endtask

    task automatic mode_press();
        key_mode_n = 1'b0;
        clk(3);
        key_mode_n = 1'b1;
        clk(3);
    endtask

    task automatic add_click();
        key_add_n = 1'b0;
        clk(3);
        key_add_n = 1'b1;
        clk(3);
    endtask

    task automatic tick();
        tick_10ms = 1'b1;
        clk(1);
        tick_10ms = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            clk(1);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (status !== 3'd0 || sec_run !== 1'b1 || show_date !== 1'b0
            || digit_en !== 4'b1111)
            $display("FAIL reset_outputs: st=%0d run=%b date=%b en=%b req 0 1 0 1111",
                     status, sec_run, show_date, digit_en);
        else passes++;
        checks++;
        if ({inc_minute, inc_hour, inc_day, inc_month} !== 4'b0000)
            $display("FAIL reset_inc: got %b req 0000",
                     {inc_minute, inc_hour, inc_day, inc_month});
        else passes++;
    endtask

    task automatic test_mode_cycle();
        logic [2:0] exp [5];
        int b;
        exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        do_reset();
        b = n_all();
        for (int i = 0; i < 5; i++) begin
            mode_press();
            checks++;
            if (status !== exp[i])
                $display("FAIL mode_step%0d: got %0d req %0d", i, status, exp[i]);
            else passes++;
            checks++;
            if (sec_run !== 1'b1)
                $display("FAIL mode_secrun%0d: got %b req 1", i, sec_run);
            else passes++;
        end
        checks++;
        if (n_all() - b != 0)
            $display("FAIL mode_noinc: got %0d pulses req 0", n_all() - b);
        else passes++;
    endtask

    task automatic test_short_add();
        int b;
        do_reset();
        mode_press();
        mode_press();
        b = n_min;
        key_add_n = 1'b0;
        clk(2);
        checks++;
        if (inc_minute !== 1'b0 || sec_run !== 1'b1)
            $display("FAIL short_early: inc=%b run=%b req 0 1", inc_minute, sec_run);
        else passes++;
        clk(1);
        checks++;
        if (inc_minute !== 1'b1 || sec_run !== 1'b0)
            $display("FAIL short_pulse: inc=%b run=%b req 1 0", inc_minute, sec_run);
        else passes++;
        clk(1);
        checks++;
        if (inc_minute !== 1'b0)
            $display("FAIL short_width: inc=%b req 0", inc_minute);
        else passes++;
        ticks(3);
        key_add_n = 1'b1;
        clk(4);
        checks++;
        if (n_min - b != 1)
            $display("FAIL short_count: got %0d req 1", n_min - b);
        else passes++;
    endtask

    task automatic test_hold_repeat();
        int b;
        logic e;
        do_reset();
        mode_press();
        b = n_hour;
        key_add_n = 1'b0;
        clk(3);
        checks++;
        if (inc_hour !== 1'b1)
            $display("FAIL hold_first: inc=%b req 1", inc_hour);
        else passes++;
        clk(2);
        for (int n = 1; n <= 79; n++) begin
            tick();
            e = (n == 50 || n == 60 || n == 70);
            checks++;
            if (inc_hour !== e)
                $display("FAIL hold_tick%0d: inc=%b req %b", n, inc_hour, e);
            else passes++;
            clk(1);
        end
        key_add_n = 1'b1;
        clk(3);
        ticks(25);
        checks++;
        if (n_hour - b != 4)
            $display("FAIL hold_count: got %0d req 4", n_hour - b);
        else passes++;
    endtask

    task automatic test_timeout();
        int b;
        do_reset();
        mode_press();
        mode_press();
        mode_press();
        b = n_month;
        add_click();
        checks++;
        if (n_month - b != 1 || sec_run !== 1'b0)
            $display("FAIL tmo_setup: pulses=%0d run=%b req 1 0",
                     n_month - b, sec_run);
        else passes++;
        ticks(999);
        tick();
        checks++;
        if (status !== 3'd3)
            $display("FAIL tmo_edge: st=%0d req 3", status);
        else passes++;
        clk(1);
        checks++;
        if (status !== 3'd0 || sec_run !== 1'b1 || digit_en !== 4'b1111)
            $display("FAIL tmo_return: st=%0d run=%b en=%b req 0 1 1111",
                     status, sec_run, digit_en);
        else passes++;
    endtask

    task automatic test_simultaneous();
        int b, bm, bd;
        do_reset();
        mode_press();
        mode_press();
        b = n_all();
        key_mode_n = 1'b0;
        key_add_n = 1'b0;
        clk(3);
        key_mode_n = 1'b1;
        clk(2);
        checks++;
        if (status !== 3'd3)
            $display("FAIL simul_status: st=%0d req 3", status);
        else passes++;
        ticks(60);
        key_add_n = 1'b1;
        clk(3);
        checks++;
        if (n_all() - b != 0 || sec_run !== 1'b1)
            $display("FAIL simul_noinc: pulses=%0d run=%b req 0 1",
                     n_all() - b, sec_run);
        else passes++;
        bm = n_month;
        bd = n_day;
        key_add_n = 1'b0;
        clk(4);
        mode_press();
        ticks(60);
        checks++;
        if (status !== 3'd4 || n_month - bm != 1 || n_day - bd != 0)
            $display("FAIL held_mode: st=%0d mon=%0d day=%0d req 4 1 0",
                     status, n_month - bm, n_day - bd);
        else passes++;
        key_add_n = 1'b1;
        clk(3);
        add_click();
        checks++;
        if (n_day - bd != 1)
            $display("FAIL repress_day: got %0d req 1", n_day - bd);
        else passes++;
    endtask

    task automatic test_blink();
        do_reset();
        repeat (4) mode_press();
        checks++;
        if (status !== 3'd4 || digit_en !== 4'b0011)
            $display("FAIL blink_entry: st=%0d en=%b req 4 0011", status, digit_en);
        else passes++;
        ticks(24);
        checks++;
        if (digit_en !== 4'b0011)
            $display("FAIL blink_t24: en=%b req 0011", digit_en);
        else passes++;
        ticks(1);
        checks++;
        if (digit_en !== 4'b0000)
            $display("FAIL blink_t25: en=%b req 0000", digit_en);
        else passes++;
        ticks(24);
        checks++;
        if (digit_en !== 4'b0000)
            $display("FAIL blink_t49: en=%b req 0000", digit_en);
        else passes++;
        ticks(1);
        checks++;
        if (digit_en !== 4'b0011)
            $display("FAIL blink_t50: en=%b req 0011", digit_en);
        else passes++;
        ticks(25);
        key_add_n = 1'b0;
        clk(2);
        checks++;
        if (digit_en !== 4'b0011)
            $display("FAIL blink_held: en=%b req 0011", digit_en);
        else passes++;
        ticks(30);
        checks++;
        if (digit_en !== 4'b0011)
            $display("FAIL blink_held30: en=%b req 0011", digit_en);
        else passes++;
        key_add_n = 1'b1;
        clk(3);
        ticks(25);
        checks++;
        if (digit_en !== 4'b0000)
            $display("FAIL blink_after: en=%b req 0000", digit_en);
        else passes++;
    endtask

    task automatic test_show_date();
        int b;
        do_reset();
        b = n_all();
        add_click();
        checks++;
        if (show_date !== 1'b1)
            $display("FAIL date_on: got %b req 1", show_date);
        else passes++;
        add_click();
        checks++;
        if (show_date !== 1'b0)
            $display("FAIL date_off: got %b req 0", show_date);
        else passes++;
        key_add_n = 1'b0;
        clk(3);
        ticks(70);
        key_add_n = 1'b1;
        clk(3);
        checks++;
        if (show_date !== 1'b1)
            $display("FAIL date_hold: got %b req 1", show_date);
        else passes++;
        mode_press();
        checks++;
        if (status !== 3'd1 || show_date !== 1'b0 || n_all() - b != 0)
            $display("FAIL date_leave: st=%0d date=%b pulses=%0d req 1 0 0",
                     status, show_date, n_all() - b);
        else passes++;
    endtask

    task automatic test_reset_midop();
        int b;
        do_reset();
        mode_press();
        key_add_n = 1'b0;
        clk(3);
        ticks(55);
        reset = 1'b0;
        clk(1);
        checks++;
        if (status !== 3'd0 || sec_run !== 1'b1 || digit_en !== 4'b1111
            || {inc_minute, inc_hour, inc_day, inc_month} !== 4'b0000)
            $display("FAIL midrst_out: st=%0d run=%b en=%b req 0 1 1111",
                     status, sec_run, digit_en);
        else passes++;
        b = n_all();
        ticks(5);
        reset = 1'b1;
        clk(2);
        ticks(70);
        checks++;
        if (n_all() - b != 0 || show_date !== 1'b0 || status !== 3'd0)
            $display("FAIL midrst_quiet: pulses=%0d date=%b st=%0d req 0 0 0",
                     n_all() - b, show_date, status);
        else passes++;
        key_add_n = 1'b1;
        clk(3);
    endtask

    task automatic test_exclusive();
        checks++;
        if (n_multi != 0)
            $display("FAIL inc_onehot: got %0d multi-high cycles req 0", n_multi);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_mode_cycle();
        test_short_add();
        test_hold_repeat();
        test_timeout();
        test_simultaneous();
        test_blink();
        test_show_date();
        test_reset_midop();
        test_exclusive();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
